and_or_pipe: RTL
================

AND_OR_PIPE -- requirements
Module: and_or_pipe

Interface
- REQ-001 Parameter WIDTH, default 8: data width of a, b, c, x and y.
- REQ-002 Parameter MODE, default MODE_SPLIT: MODE_FUSED gives 1-stage latency; MODE_SPLIT gives 2-stage latency.
- REQ-003 clk  input  1  single clock; all state updates on its rising edge.
- REQ-004 reset_n  input  1  reset, asynchronous and active-low.
- REQ-005 in_valid  input  1  operands a/b/c valid this cycle.
- REQ-006 in_ready  output  1  block accepts operands this cycle.
- REQ-007 a, b, c  input  WIDTH each  operands.
- REQ-008 out_valid  output  1  x/y hold a valid result.
- REQ-009 out_ready  input  1  consumer accepts the result this cycle.
- REQ-010 x  output  WIDTH  a&b of the result's transaction.
- REQ-011 y  output  WIDTH  (a&b)|c of the same transaction.
- REQ-012 txn_count  output  16  completed output transfers; present only with AND_OR_PIPE_CNT_EN.

Function
- REQ-013 An input transfer shall occur on each edge where in_valid && in_ready; an output transfer on each edge where out_valid && out_ready.
- REQ-014 In MODE_FUSED, the result of a transfer shall appear with out_valid high on the cycle after acceptance: x=a&b, y=(a&b)|c, latency 1.
- REQ-015 In MODE_SPLIT:
  - stage 1 registers x1=a&b with c1=c;
  - stage 2 registers x=x1 and y=x1|c1;
  - latency 2;
  - c shall stay aligned with its own transaction, never a neighbour's.
- REQ-016 Each stage shall be a valid/ready register slice: stage ready = !stage_valid || downstream_ready.
- REQ-017 in_ready shall be the ready of stage 1.
- REQ-018 With both ready signals held high, one transfer per cycle shall be sustained with no bubbles.
- REQ-019 While out_valid && !out_ready, x and y shall hold stable.
- REQ-020 Under stall, every stage shall hold its contents; no transaction shall be dropped or duplicated.
- REQ-021 When a stage's data leaves on the same edge new data enters, the stage shall hold the new data with valid high.
- REQ-022 Inputs a/b/c shall be ignored whenever in_valid is low or in_ready is low.
- REQ-023 Results shall emerge in acceptance order.

Reset
- REQ-024 While reset_n is low, all stage valid flags, x, y and txn_count shall be 0.
- REQ-025 in_ready shall be 1 while reset_n is low, because stages are empty and reset clears valid.
- REQ-026 Reset asserted mid-operation shall discard all in-flight transactions immediately, without waiting for clk.
- REQ-027 The first edge after reset_n rises shall accept input normally.

Configuration
- REQ-028 With macro AND_OR_PIPE_CNT_EN defined, txn_count shall increment by 1 on each output transfer and wrap from 0xFFFF to 0x0000.
- REQ-029 Without AND_OR_PIPE_CNT_EN, the txn_count port and its counter shall not exist; all other behaviour is unchanged.

Structure
- REQ-030 Package and_or_pipe_pkg shall hold:
  - enum mode_e {MODE_FUSED, MODE_SPLIT};
  - constant DEFAULT_WIDTH = 8;
  - constant CNT_WIDTH = 16.
- REQ-031 Sub-module pipe_slice, parametrised on payload width, shall implement REQ-016 to REQ-021.
- REQ-032 and_or_pipe shall instantiate pipe_slice once in MODE_FUSED and twice in MODE_SPLIT.
- REQ-033 All state shall use nonblocking assignment so stage order never alters results.

Verification
- REQ-034 Split mode, single transaction: WIDTH=8, in_valid for 1 cycle with a=0xF0, b=0x3C, c=0x01, out_ready=1. Required: out_valid 2 cycles later with x=0x30, y=0x31.
- REQ-035 Fused mode, same stimulus. Required: out_valid 1 cycle later with x=0x30, y=0x31.
- REQ-036 Streaming: send 8 back-to-back transactions with c=index 0..7, a=b=0xFF, out_ready=1. Required:
  - one result per cycle;
  - y=0xFF for every transaction;
  - x=0xFF;
  - txn_count=8 (macro defined).
- REQ-037 Backpressure (split mode): hold out_ready=0 and offer 3 transactions. Required:
  - the first 2 are accepted, then in_ready=0;
  - x/y are stable;
  - releasing out_ready drains the transactions in order, with none lost or duplicated.
- REQ-038 Reset mid-flight: assert reset_n=0 with 2 transactions in flight. Required:
  - out_valid=0 and x=y=0 immediately;
  - txn_count=0;
  - no stale output after release.
- REQ-039 Counter wrap: preload via 65536 transfers. Required: txn_count reads 0x0000 after the 65536th transfer.

Source files
------------

// File: rtl/and_or_pipe_pkg.sv
// Shared types and constants for the and_or_pipe datapath.
// Optional transfer counter is enabled by defining AND_OR_PIPE_CNT_EN.
package and_or_pipe_pkg;

    typedef enum logic {
        MODE_FUSED = 1'b0,
        MODE_SPLIT = 1'b1
    } mode_e;

    localparam int DEFAULT_WIDTH = 8;
    localparam int CNT_WIDTH     = 16;

endpackage

// File: rtl/and_or_pipe_if.sv
// Operand/result bus of and_or_pipe; clock and reset stay outside.
// A transfer happens on a rising edge where valid && ready; a producer holds its payload until then.
interface and_or_pipe_if #(
    parameter int WIDTH = and_or_pipe_pkg::DEFAULT_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;

    modport master (
        output in_valid,
        output a,
        output b,
        output c,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  x,
        input  y
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  c,
        input  out_ready,
        output in_ready,
        output out_valid,
        output x,
        output y
    );

endinterface

// File: rtl/and_or_pipe_pipe_slice.sv
// One valid/ready register slice: full throughput, holds payload under stall.
module pipe_slice #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         valid_q;
    logic         valid_d;
    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    // Ready when empty or when the occupant leaves on this same edge.
    assign in_ready = !valid_q || out_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_ready) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d = in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/and_or_pipe.sv
// x = a&b, y = (a&b)|c through one (MODE_FUSED) or two (MODE_SPLIT) register slices.
// Define AND_OR_PIPE_CNT_EN to add the txn_count output-transfer counter.
module and_or_pipe
    import and_or_pipe_pkg::*;
#(
    parameter int    WIDTH = DEFAULT_WIDTH,
    parameter mode_e MODE  = MODE_SPLIT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    and_or_pipe_if.slave         bus
`ifdef AND_OR_PIPE_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] txn_count
`endif
);

    logic [WIDTH-1:0] and_ab;

    assign and_ab = bus.a & bus.b;

    generate
        if (MODE == MODE_FUSED) begin : g_fused
            logic [2*WIDTH-1:0] res_data;

            pipe_slice #(.W(2*WIDTH)) u_slice (
                .clk       (clk),
                .reset_n   (reset_n),
                .in_valid  (bus.in_valid),
                .in_ready  (bus.in_ready),
                .in_data   ({and_ab, and_ab | bus.c}),
                .out_valid (bus.out_valid),
                .out_ready (bus.out_ready),
                .out_data  (res_data)
            );

            assign bus.x = res_data[2*WIDTH-1:WIDTH];
            assign bus.y = res_data[WIDTH-1:0];
        end else begin : g_split
            logic               s1_valid;
            logic               s1_ready;
            logic [2*WIDTH-1:0] s1_data;
            logic [WIDTH-1:0]   x1;
            logic [WIDTH-1:0]   c1;
            logic [2*WIDTH-1:0] res_data;

            // c rides in the same payload word as a&b so it can never slip to a neighbour.
            pipe_slice #(.W(2*WIDTH)) u_stage1 (
                .clk       (clk),
                .reset_n   (reset_n),
                .in_valid  (bus.in_valid),
                .in_ready  (bus.in_ready),
                .in_data   ({and_ab, bus.c}),
                .out_valid (s1_valid),
                .out_ready (s1_ready),
                .out_data  (s1_data)
            );

            assign x1 = s1_data[2*WIDTH-1:WIDTH];
            assign c1 = s1_data[WIDTH-1:0];

            pipe_slice #(.W(2*WIDTH)) u_stage2 (
                .clk       (clk),
                .reset_n   (reset_n),
                .in_valid  (s1_valid),
                .in_ready  (s1_ready),
                .in_data   ({x1, x1 | c1}),
                .out_valid (bus.out_valid),
                .out_ready (bus.out_ready),
                .out_data  (res_data)
            );

            assign bus.x = res_data[2*WIDTH-1:WIDTH];
            assign bus.y = res_data[WIDTH-1:0];
        end
    endgenerate

`ifdef AND_OR_PIPE_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    // Wraps naturally at 2**CNT_WIDTH.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.out_valid && bus.out_ready) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign txn_count = cnt_q;
`endif

endmodule
